// File: rtl/sprite_pkg.sv
// Shared sprite types, key indices and default geometry.
// Also used by the renderer and collision blocks.
package sprite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_FROZEN
    } state_e;

    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;

    localparam int DEF_W            = 10;
    localparam int DEF_X_MIN        = 20;
    localparam int DEF_X_MAX        = 659;
    localparam int DEF_Y_MIN        = 20;
    localparam int DEF_Y_MAX        = 459;
    localparam int DEF_X_INIT       = 340;
    localparam int DEF_Y_INIT       = 400;
    localparam int DEF_STEP_MIN     = 1;
    localparam int DEF_STEP_MAX     = 4;
    localparam int DEF_RAMP_TICKS   = 8;
    localparam int DEF_FREEZE_TICKS = 60;

    // Opposing keys cancel: +1, -1 or 0.
    function automatic logic signed [1:0] key_dir(
        input logic inc,
        input logic dec
    );
        if (inc && !dec) begin
            return 2'sd1;
        end
        if (dec && !inc) begin
            return -2'sd1;
        end
        return 2'sd0;
    endfunction

endpackage

// File: rtl/axis_step.sv
// Clamped single-axis step adder.
// Sums are formed one bit wider so they cannot wrap.
module axis_step #(
    parameter int W = 10
) (
    input  logic [W-1:0]      pos,
    input  logic signed [1:0] dir,
    input  logic [2:0]        step,
    input  logic [W-1:0]      min_b,
    input  logic [W-1:0]      max_b,
    output logic [W-1:0]      next
);

    logic [W:0] up_sum;
    logic [W:0] lo_lim;

    assign up_sum = {1'b0, pos} + (W+1)'(step);
    assign lo_lim = {1'b0, min_b} + (W+1)'(step);

    always_comb begin
        next = pos;
        if (dir == 2'sd1) begin
            next = (up_sum > {1'b0, max_b}) ? max_b : up_sum[W-1:0];
        end else if (dir == -2'sd1) begin
            next = ({1'b0, pos} < lo_lim) ? min_b : pos - W'(step);
        end
    end

endmodule

// File: rtl/sprite_pos_ctrl.sv
// 2-D sprite position controller with speed ramp,
// exact bound clamping and hit-triggered freeze.
module sprite_pos_ctrl
    import sprite_pkg::*;
#(
    parameter int W            = DEF_W,
    parameter int X_MIN        = DEF_X_MIN,
    parameter int X_MAX        = DEF_X_MAX,
    parameter int Y_MIN        = DEF_Y_MIN,
    parameter int Y_MAX        = DEF_Y_MAX,
    parameter int X_INIT       = DEF_X_INIT,
    parameter int Y_INIT       = DEF_Y_INIT,
    parameter int STEP_MIN     = DEF_STEP_MIN,
    parameter int STEP_MAX     = DEF_STEP_MAX,
    parameter int RAMP_TICKS   = DEF_RAMP_TICKS,
    parameter int FREEZE_TICKS = DEF_FREEZE_TICKS
) (
    input  logic         game_clk,
    input  logic         reset,
    input  logic [3:0]   key_n,
    input  logic         hit,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output logic [2:0]   speed,
    output logic         frozen,
    output logic [3:0]   at_edge
);

    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int FW = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;

    localparam logic [W-1:0] XMIN = W'(X_MIN);
    localparam logic [W-1:0] XMAX = W'(X_MAX);
    localparam logic [W-1:0] YMIN = W'(Y_MIN);
    localparam logic [W-1:0] YMAX = W'(Y_MAX);
    localparam logic [W-1:0] XINI = W'(X_INIT);
    localparam logic [W-1:0] YINI = W'(Y_INIT);
    localparam logic [2:0]   SMIN = 3'(STEP_MIN);
    localparam logic [2:0]   SMAX = 3'(STEP_MAX);
    localparam logic [RW-1:0] RLAST = RW'(RAMP_TICKS - 1);
    localparam logic [FW-1:0] FLAST = FW'(FREEZE_TICKS - 1);

    if (!(X_MIN <= X_INIT && X_INIT <= X_MAX &&
          Y_MIN <= Y_INIT && Y_INIT <= Y_MAX &&
          1 <= STEP_MIN && STEP_MIN <= STEP_MAX &&
          STEP_MAX <= 7)) begin : g_bad_param
        $error("sprite_pos_ctrl: illegal parameter set");
    end

    state_e        state_q, state_d;
    logic [W-1:0]  pos_x_q, pos_x_d;
    logic [W-1:0]  pos_y_q, pos_y_d;
    logic [2:0]    speed_q, speed_d;
    logic          frozen_q, frozen_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic [FW-1:0] frz_q, frz_d;

    logic signed [1:0] dir_x;
    logic signed [1:0] dir_y;
    logic [W-1:0]      nx_x;
    logic [W-1:0]      nx_y;
    logic              moving;

    assign dir_x  = key_dir(~key_n[KEY_RIGHT], ~key_n[KEY_LEFT]);
    assign dir_y  = key_dir(~key_n[KEY_DOWN], ~key_n[KEY_UP]);
    assign moving = (dir_x != 2'sd0) || (dir_y != 2'sd0);

    axis_step #(.W(W)) u_step_x (
        .pos   (pos_x_q),
        .dir   (dir_x),
        .step  (speed_q),
        .min_b (XMIN),
        .max_b (XMAX),
        .next  (nx_x)
    );

    axis_step #(.W(W)) u_step_y (
        .pos   (pos_y_q),
        .dir   (dir_y),
        .step  (speed_q),
        .min_b (YMIN),
        .max_b (YMAX),
        .next  (nx_y)
    );

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        speed_d  = speed_q;
        frozen_d = frozen_q;
        ramp_d   = ramp_q;
        frz_d    = frz_q;
        if (hit) begin
            state_d  = ST_FROZEN;
            pos_x_d  = XINI;
            pos_y_d  = YINI;
            speed_d  = SMIN;
            frozen_d = 1'b1;
            ramp_d   = '0;
            frz_d    = '0;
        end else begin
            unique case (state_q)
                ST_FROZEN: begin
                    if (frz_q == FLAST) begin
                        state_d  = ST_IDLE;
                        frozen_d = 1'b0;
                        frz_d    = '0;
                    end else begin
                        frz_d = frz_q + 1'b1;
                    end
                end
                ST_IDLE, ST_MOVE: begin
                    // Speed is always STEP_MIN in IDLE, so one path serves both.
                    if (moving) begin
                        state_d = ST_MOVE;
                        pos_x_d = nx_x;
                        pos_y_d = nx_y;
                        if (speed_q >= SMAX) begin
                            ramp_d = '0;
                        end else if (ramp_q == RLAST) begin
                            speed_d = speed_q + 1'b1;
                            ramp_d  = '0;
                        end else begin
                            ramp_d = ramp_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        speed_d = SMIN;
                        ramp_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pos_x_q  <= XINI;
            pos_y_q  <= YINI;
            speed_q  <= SMIN;
            frozen_q <= 1'b0;
            ramp_q   <= '0;
            frz_q    <= '0;
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            speed_q  <= speed_d;
            frozen_q <= frozen_d;
            ramp_q   <= ramp_d;
            frz_q    <= frz_d;
        end
    end

    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;
    assign speed  = speed_q;
    assign frozen = frozen_q;

    assign at_edge = {pos_y_q == YMAX, pos_y_q == YMIN,
                      pos_x_q == XMIN, pos_x_q == XMAX};

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Randomised and directed bench for sprite_pos_ctrl
// against a plain-integer behavioural model.
module tb_sprite_pos_ctrl;

    localparam int W      = 10;
    localparam int XMIN   = 20;
    localparam int XMAX   = 659;
    localparam int YMIN   = 20;
    localparam int YMAX   = 459;
    localparam int XINIT  = 340;
    localparam int YINIT  = 400;
    localparam int SMIN   = 1;
    localparam int SMAX   = 4;
    localparam int RAMP   = 8;
    localparam int FREEZE = 60;

    logic         game_clk;
    logic         reset;
    logic [3:0]   key_n;
    logic         hit;
    logic [W-1:0] pos_x;
    logic [W-1:0] pos_y;
    logic [2:0]   speed;
    logic         frozen;
    logic [3:0]   at_edge;

    int n_chk;
    int n_fail;

    int m_x, m_y, m_spd, m_moves, m_frz_cnt;
    bit m_frozen;

    sprite_pos_ctrl dut (
        .game_clk (game_clk),
        .reset    (reset),
        .key_n    (key_n),
        .hit      (hit),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .speed    (speed),
        .frozen   (frozen),
        .at_edge  (at_edge)
    );

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_x = XINIT;
        m_y = YINIT;
        m_spd = SMIN;
        m_moves = 0;
        m_frz_cnt = 0;
        m_frozen = 0;
    endtask

    task automatic model_tick(input logic [3:0] k, input logic h);
        int dx, dy;
        if (h) begin
            model_reset();
            m_frozen = 1;
            return;
        end
        if (m_frozen) begin
            m_frz_cnt++;
            if (m_frz_cnt == FREEZE) begin
                m_frozen = 0;
                m_frz_cnt = 0;
            end
            return;
        end
        dx = int'(!k[0]) - int'(!k[1]);
        dy = int'(!k[3]) - int'(!k[2]);
        if (dx == 0 && dy == 0) begin
            m_spd = SMIN;
            m_moves = 0;
            return;
        end
        m_x = clamp(m_x + dx * m_spd, XMIN, XMAX);
        m_y = clamp(m_y + dy * m_spd, YMIN, YMAX);
        // Every RAMP moving cycles at one speed earn one more unit.
        if (m_spd < SMAX) begin
            m_moves++;
            if (m_moves == RAMP) begin
                m_spd++;
                m_moves = 0;
            end
        end
    endtask

    task automatic check_all();
        int e;
        e = (int'(m_y == YMAX) << 3) | (int'(m_y == YMIN) << 2) |
            (int'(m_x == XMIN) << 1) | int'(m_x == XMAX);
        chk("pos_x", int'(pos_x), m_x);
        chk("pos_y", int'(pos_y), m_y);
        chk("speed", int'(speed), m_spd);
        chk("frozen", int'(frozen), int'(m_frozen));
        chk("at_edge", int'(at_edge), e);
    endtask

    task automatic step(input logic [3:0] k, input logic h);
        key_n = k;
        hit = h;
        @(posedge game_clk);
        model_tick(k, h);
        #1;
        hit = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2;
        reset = 1'b0;
    endtask

    int cnt;
    int seg;
    logic [3:0] rk;

    initial begin
        n_chk = 0;
        n_fail = 0;
        key_n = 4'hF;
        hit = 1'b0;
        reset = 1'b0;
        model_reset();
        #3;
        do_reset();
        chk("rst_x", int'(pos_x), 340);
        chk("rst_y", int'(pos_y), 400);
        chk("rst_speed", int'(speed), 1);
        chk("rst_frozen", int'(frozen), 0);

        step(4'b1110, 0);
        chk("one_right_x", int'(pos_x), 341);
        chk("one_right_y", int'(pos_y), 400);

        do_reset();
        for (int i = 0; i < 8; i++) step(4'b1110, 0);
        chk("ramp8_x", int'(pos_x), 348);
        chk("ramp8_speed", int'(speed), 2);
        step(4'b1110, 0);
        chk("ramp9_x", int'(pos_x), 350);
        step(4'b1111, 0);
        chk("release_speed", int'(speed), 1);

        do_reset();
        for (int i = 0; i < 200; i++) step(4'b1110, 0);
        chk("right_bound", int'(pos_x), 659);
        chk("right_edge", int'(at_edge[0]), 1);
        chk("right_sat", int'(speed), 4);
        for (int i = 0; i < 250; i++) step(4'b1101, 0);
        chk("left_bound", int'(pos_x), 20);
        chk("left_edge", int'(at_edge[1]), 1);

        do_reset();
        for (int i = 0; i < 20; i++) step(4'b1100, 0);
        chk("cancel_x", int'(pos_x), 340);
        chk("cancel_speed", int'(speed), 1);
        step(4'b0100, 0);
        chk("cancel_down_x", int'(pos_x), 340);
        chk("cancel_down_y", int'(pos_y), 401);

        do_reset();
        cnt = 0;
        while (pos_x < 500 && cnt < 300) begin
            step(4'b1110, 0);
            cnt++;
        end
        step(4'b1110, 1);
        chk("hit_x", int'(pos_x), 340);
        chk("hit_frozen", int'(frozen), 1);
        for (int i = 0; i < 30; i++) step(4'b1110, 0);
        step(4'b1110, 1);
        cnt = 1;
        while (frozen && cnt < 200) begin
            step(4'b1110, 0);
            if (frozen) cnt++;
        end
        chk("refreeze_len", cnt, 60);
        chk("unfreeze_x", int'(pos_x), 340);
        step(4'b1110, 0);
        chk("resume_x", int'(pos_x), 341);

        step(4'b1110, 1);
        for (int i = 0; i < 10; i++) step(4'b1110, 0);
        do_reset();
        chk("rst_mid_frz", int'(frozen), 0);
        for (int i = 0; i < 12; i++) step(4'b0111, 0);
        do_reset();
        chk("rst_mid_ramp", int'(speed), 1);
        step(4'b0111, 0);
        chk("post_rst_y", int'(pos_y), 401);

        for (int s = 0; s < 250; s++) begin
            rk = 4'($urandom_range(0, 15));
            seg = $urandom_range(1, 24);
            for (int i = 0; i < seg; i++) begin
                step(rk, ($urandom_range(0, 79) == 0));
            end
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
